load_store_unit: RTL
====================

Name: load_store_unit

Overview:
- Initiator-side master for the word-addressed data memory: takes one load/store request from the core pipeline and drives the memory's write port (writeaddr/writedata/writeenable) and its combinational read port (readaddr/readdata).
- Adds byte/halfword loads with sign/zero extension, and byte/halfword stores via read-modify-write, because the memory only writes full 32-bit words.
- Adds misalignment, illegal-funct3 and out-of-range checks.
- Sits between the execute stage and the memory; one request in flight at a time.

Parameters:
- SIZE, 256, memory depth in 32-bit words; word index addr[31:2] >= SIZE is an access fault.

Ports:
- clk  input  1  system clock, all state on posedge
- reset  input  1  synchronous, active-high reset
- req_valid  input  1  request present
- req_ready  output  1  unit can accept a request (high only in IDLE)
- req_write  input  1  1 = store, 0 = load
- req_funct3  input  3  RISC-V width/sign code
- req_addr  input  32  byte address
- req_wdata  input  32  store data (low byte/half used for sb/sh)
- resp_valid  output  1  response available
- resp_ready  input  1  consumer accepts response
- resp_rdata  output  32  load result, extended; 0 for stores and errors
- resp_error  output  1  misaligned, illegal funct3 or out-of-range
- mem_readaddr  output  32  to memory readaddr
- mem_readdata  input  32  from memory readdata (combinational, same cycle)
- mem_writeaddr  output  32  to memory writeaddr
- mem_writedata  output  32  to memory writedata
- mem_writeenable  output  1  to memory writeenable

Behaviour:
- One clock; synchronous active-high reset.
- Reset state is IDLE. All latched registers (addr, wdata, funct3, write, merged word, result, error) are cleared to 0.
- Output values at reset: req_ready=1, resp_valid=0, resp_rdata=0, resp_error=0, mem_writeenable=0, mem_readaddr=mem_writeaddr=mem_writedata=0.
- mem_readaddr = mem_writeaddr = {lat_addr[31:2],2'b00} in every state.
- mem_writedata = merged register.
- mem_writeenable = (state==WRITE) && !reset.
- Legal funct3:
  - Loads: 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu.
  - Stores: 000 sb, 001 sh, 010 sw.
  - Any other code is an error.
- Error checks:
  - Misaligned: halfword with addr[0]=1, or word with addr[1:0]!=0.
  - Out-of-range: addr[31:2] >= SIZE.
- FSM:
  - IDLE: req_ready=1. A request is accepted when req_valid=1 (the handshake completes this cycle) and its fields are latched.
    - Any error -> RESP with resp_error=1.
    - Load -> LOAD.
    - sw -> WRITE, with merged = req_wdata.
    - sb/sh -> RMW.
  - LOAD: sample mem_readdata and select the lane by addr[1:0] (byte) or addr[1] (half). Sign-extend for lb/lh, zero-extend for lbu/lhu. Store into result -> RESP.
  - RMW: sample mem_readdata and replace only the addressed byte/half lane with wdata[7:0] or wdata[15:0] -> WRITE.
  - WRITE: mem_writeenable=1 for exactly this cycle; result=0 -> RESP.
  - RESP: resp_valid=1 with result and error stable. When resp_ready=1 -> IDLE; otherwise hold.
- Latency from the accept cycle T to the first resp_valid cycle:
  - Load: T+2.
  - sw: T+2 (memory updated at the end of T+1).
  - sb/sh: T+3.
  - Error: T+1.
- An error never asserts mem_writeenable and never changes memory.
- No new accept while a response is pending. Back-to-back throughput is 1 request per 3 cycles for loads/sw when resp_ready is held high.
- Reset mid-operation: the unit returns to IDLE on the next edge. If reset coincides with WRITE, no write occurs. The pending response is dropped.
- resp_ready while resp_valid=0 is ignored. req_valid/req_* outside IDLE are ignored.

Test Plan:
- mem[1]=0x8081_82F3. lb @0x4 -> 0xFFFF_FFF3; lbu @0x7 -> 0x0000_0080; lh @0x6 -> 0xFFFF_8081; lhu @0x4 -> 0x0000_82F3. resp_valid at T+2, resp_error=0.
- mem[2]=0x1122_3344. sb 0xAB @0x9 -> mem[2]=0x1122_AB44, writeenable high exactly at T+2. sh 0xBEEF @0xA -> 0xBEEF_AB44. sw 0xDEAD_BEEF @0x8 -> writeenable at T+1, mem[2]=0xDEAD_BEEF.
- lw @0x6, sh @0x3, funct3=011 load, sw @0x400 (word index 256, SIZE=256) -> each gives resp_error=1 at T+1, resp_rdata=0, writeenable never asserted, memory unchanged.
- Load @0x4 with resp_ready=0 for 5 cycles -> resp_valid and resp_rdata held stable, req_ready=0, a new req_valid ignored. Raise resp_ready -> IDLE next cycle, and the next request is accepted.
- sb issued, reset asserted in the WRITE cycle -> mem word unchanged, next cycle req_ready=1 and resp_valid=0. A subsequent lw returns the original value.
- 100 random legal/illegal requests with random resp_ready stalls against a reference memory model -> all responses and final memory contents match.

Source files
------------

// File: rtl/load_store_unit_if.sv
// Bundles the core-side request/response handshake and the data-memory port of the load/store unit.
interface load_store_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_error;
  logic [31:0] mem_readaddr;
  logic [31:0] mem_readdata;
  logic [31:0] mem_writeaddr;
  logic [31:0] mem_writedata;
  logic        mem_writeenable;

  modport slave (
    input  req_valid, req_write, req_funct3, req_addr, req_wdata, resp_ready, mem_readdata,
    output req_ready, resp_valid, resp_rdata, resp_error,
    output mem_readaddr, mem_writeaddr, mem_writedata, mem_writeenable
  );

  modport master (
    output req_valid, req_write, req_funct3, req_addr, req_wdata, resp_ready, mem_readdata,
    input  req_ready, resp_valid, resp_rdata, resp_error,
    input  mem_readaddr, mem_writeaddr, mem_writedata, mem_writeenable
  );
endinterface

// File: rtl/load_store_unit.sv
// Single-outstanding load/store master for a word-wide memory: sub-word loads with extension,
// sub-word stores by read-modify-write, and alignment / funct3 / range checking.
module load_store_unit #(
  parameter int SIZE = 256
) (
  input logic               clk,
  input logic               reset,
  load_store_unit_if.slave  bus
);
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RMW, S_WRITE, S_RESP} state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_merged;
  logic [31:0] r_result;
  logic [2:0]  r_funct3;
  logic        r_write;
  logic        r_error;

  logic        w_legal;
  logic        w_misaligned;
  logic        w_out_of_range;
  logic        w_req_error;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load_value;
  logic [31:0] w_rmw_word;

  always_comb begin
    w_legal = 1'b0;
    case (bus.req_funct3)
      3'b000, 3'b001, 3'b010: w_legal = 1'b1;
      3'b100, 3'b101:         w_legal = !bus.req_write;
      default:                w_legal = 1'b0;
    endcase
  end

  // funct3[1:0] encodes width for both loads and stores: 00 byte, 01 half, 10 word
  assign w_misaligned   = ((bus.req_funct3[1:0] == 2'b01) && bus.req_addr[0]) ||
                          ((bus.req_funct3[1:0] == 2'b10) && (bus.req_addr[1:0] != 2'b00));
  assign w_out_of_range = ({2'b00, bus.req_addr[31:2]} >= 32'(SIZE));
  assign w_req_error    = !w_legal || w_misaligned || w_out_of_range;

  always_comb begin
    w_byte = bus.mem_readdata[8*r_addr[1:0] +: 8];
    w_half = r_addr[1] ? bus.mem_readdata[31:16] : bus.mem_readdata[15:0];
    case (r_funct3)
      3'b000:  w_load_value = {{24{w_byte[7]}}, w_byte};
      3'b001:  w_load_value = {{16{w_half[15]}}, w_half};
      3'b100:  w_load_value = {24'h0, w_byte};
      3'b101:  w_load_value = {16'h0, w_half};
      default: w_load_value = bus.mem_readdata;
    endcase
  end

  // Each byte lane keeps the memory value unless it is covered by the pending sb/sh
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      localparam logic [1:0] LANE = 2'(gi);
      logic w_sel;
      logic [7:0] w_src;
      assign w_sel = r_funct3[0] ? (r_addr[1] == LANE[1]) : (r_addr[1:0] == LANE);
      assign w_src = (r_funct3[0] && LANE[0]) ? r_wdata[15:8] : r_wdata[7:0];
      assign w_rmw_word[8*gi +: 8] = w_sel ? w_src : bus.mem_readdata[8*gi +: 8];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (bus.req_valid) begin
          if (w_req_error)                   w_state_next = S_RESP;
          else if (!bus.req_write)           w_state_next = S_LOAD;
          else if (bus.req_funct3 == 3'b010) w_state_next = S_WRITE;
          else                               w_state_next = S_RMW;
        end
      end
      S_LOAD:  w_state_next = S_RESP;
      S_RMW:   w_state_next = S_WRITE;
      S_WRITE: w_state_next = S_RESP;
      S_RESP:  if (bus.resp_ready) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    bus.req_ready       = (r_state == S_IDLE);
    bus.resp_valid      = (r_state == S_RESP);
    bus.mem_writeenable = (r_state == S_WRITE) && !reset;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_addr   <= 32'h0;
      r_wdata  <= 32'h0;
      r_funct3 <= 3'b000;
      r_write  <= 1'b0;
      r_merged <= 32'h0;
      r_result <= 32'h0;
      r_error  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.req_valid) begin
            r_addr   <= bus.req_addr;
            r_wdata  <= bus.req_wdata;
            r_funct3 <= bus.req_funct3;
            r_write  <= bus.req_write;
            r_merged <= bus.req_wdata;
            r_result <= 32'h0;
            r_error  <= w_req_error;
          end
        end
        S_LOAD:  r_result <= w_load_value;
        S_RMW:   r_merged <= w_rmw_word;
        S_WRITE: r_result <= 32'h0;
        default: ;
      endcase
    end
  end

  assign bus.resp_rdata    = r_result;
  assign bus.resp_error    = r_error;
  assign bus.mem_readaddr  = {r_addr[31:2], 2'b00};
  assign bus.mem_writeaddr = {r_addr[31:2], 2'b00};
  assign bus.mem_writedata = r_merged;
endmodule
